// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package serial_subtractor_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit counter must index 0..w-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_4bit_full_adder.sv
// Single 1-bit full-adder cell, reused every cycle by the serial subtractor.
module full_adder_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry_in,
    output logic o_sum,
    output logic o_carry_out
);

    logic w_p;

    assign w_p         = i_a ^ i_b;
    assign o_sum       = w_p ^ i_carry_in;
    assign o_carry_out = (i_a & i_b) | (i_carry_in & w_p);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock,
// implemented as a + ~b + ~borrow_in through one shared full-adder cell.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_borrow;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_next_sr;

    full_adder_1bit u_fa (
        .i_a         (r_a[0]),
        .i_b         (~r_b[0]),
        .i_carry_in  (r_c),
        .o_sum       (w_sum),
        .o_carry_out (w_cout)
    );

    assign w_next_sr = {w_sum, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sr     <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= ~borrow_in;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cout;
                    r_sr  <= w_next_sr;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Result register only moves on completion, so partial bits never show on diff.
                    if (r_cnt == LAST_BIT) begin
                        r_diff   <= w_next_sr;
                        r_borrow <= ~w_cout;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == ST_SHIFT);
    assign valid      = (r_state == ST_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
